muldiv_unit: RTL

- Iterative RV32M multiply/divide execute unit; sits directly downstream of RegisterFile.
- Consumes RD1/RD2 operand values and the destination register index.
- Produces a result with a write-enable that drives the RegisterFile write port (WD, WR1, RegWrite) through writeback.
- Processes one operation at a time using a start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Shift-add multiply (64-bit accumulator) and restoring divide, one bit per
// cycle, with a start/busy/done handshake and a flush that drops the result.
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply leaves its loop as soon
// as the remaining multiplier bits are all zero.
//
// Handshake: start is taken only in IDLE with flush low; busy is high from the
// cycle after acceptance until done; done is a one-cycle pulse and result,
// rd_out and wb_en are meaningful only while done is high; flush aborts any
// non-IDLE state and outranks start.
module muldiv_unit #(
   parameter int Width = 32,
   parameter int Iters = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [Width-1:0] rs1_val,
   input  logic [Width-1:0] rs2_val,
   input  logic [4:0]       rd_in,
   output logic             busy,
   output logic             done,
   output logic [Width-1:0] result,
   output logic [4:0]       rd_out,
   output logic             wb_en,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIN = 2'd3} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q;
   logic [4:0]         rd_q;
   logic               sign_q;
   logic [5:0]         cnt_q;
   logic [2*Width-1:0] acc_q;     // product, or quotient in the low half
   logic [2*Width-1:0] mcand_q;   // shifted multiplicand, or divisor in the low half
   logic [Width-1:0]   mplier_q;  // multiplier shifted right, or dividend shifted left
   logic [Width-1:0]   rem_q;     // partial remainder (always below the divisor)
   logic               done_q;
   logic [Width-1:0]   result_q;
   logic [4:0]         rd_out_q;

   logic               accept, fin_fire, last_iter, mul_exit;
   logic               a_neg, b_neg, signed_a, signed_b, sign_new;
   logic               div_zero, div_ovf, div_fast;
   logic [Width-1:0]   a_abs, b_abs, opa, opb;
   logic [2*Width-1:0] mul_acc_d, prod_s;
   logic [Width-1:0]   mplier_shr, div_sub, rem_d, quot_s, rem_s, fin_val;
   logic [Width:0]     div_shift;  // 33-bit trial remainder
   logic               div_ge;
   state_e             mul_entry;

   // Operand decode at acceptance: magnitudes, result sign, divide fast path.
   always_comb begin
      a_neg    = rs1_val[Width-1];
      b_neg    = rs2_val[Width-1];
      a_abs    = a_neg ? -rs1_val : rs1_val;
      b_abs    = b_neg ? -rs2_val : rs2_val;
      signed_a = 1'b0;
      signed_b = 1'b0;
      sign_new = 1'b0;
      case (op)
         3'd1, 3'd4: begin signed_a = 1'b1; signed_b = 1'b1; sign_new = a_neg ^ b_neg; end
         3'd6:       begin signed_a = 1'b1; signed_b = 1'b1; sign_new = a_neg; end
         3'd2:       begin signed_a = 1'b1; sign_new = a_neg; end
         default:    ;
      endcase
      opa      = signed_a ? a_abs : rs1_val;
      opb      = signed_b ? b_abs : rs2_val;
      div_zero = (rs2_val == '0);
      div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                 (rs1_val == {1'b1, {(Width-1){1'b0}}}) && (rs2_val == '1);
      div_fast = div_zero | div_ovf;
      accept   = (state_q == S_IDLE) && start && !flush;
   end

   // One iteration step of each loop plus the final sign fix-up and select.
   always_comb begin
      mul_acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
      mplier_shr = mplier_q >> 1;
      div_shift  = {rem_q, mplier_q[Width-1]};
      div_ge     = (div_shift >= {1'b0, mcand_q[Width-1:0]});
      // The true difference is below the divisor, so the low bits are exact.
      div_sub    = div_shift[Width-1:0] - mcand_q[Width-1:0];
      rem_d      = div_ge ? div_sub : div_shift[Width-1:0];
      last_iter  = (cnt_q == 6'(Iters-1));
`ifdef MULDIV_EARLY_OUT_EN
      mul_exit   = last_iter || (mplier_shr == '0);
      mul_entry  = (opb == '0) ? S_FIN : S_MUL;
`else
      mul_exit   = last_iter;
      mul_entry  = S_MUL;
`endif
      prod_s     = sign_q ? -acc_q : acc_q;
      quot_s     = sign_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
      rem_s      = sign_q ? -rem_q : rem_q;
      if (op_q[2])
         fin_val = op_q[1] ? rem_s : quot_s;
      else
         fin_val = (op_q == 3'd0) ? prod_s[Width-1:0] : prod_s[2*Width-1:Width];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; flush wins over everything outside IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = op[2] ? (div_fast ? S_FIN : S_DIV) : mul_entry;
         S_MUL:  if (mul_exit) state_d = S_FIN;
         S_DIV:  if (last_iter) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // Output decode.
   always_comb begin
      busy        = (state_q != S_IDLE);
      fin_fire    = (state_q == S_FIN) && !flush;
      done        = done_q;
      result      = result_q;
      rd_out      = rd_out_q;
      wb_en       = done_q && (rd_out_q != 5'd0);
      dbg_state_o = state_q;
   end

   // Datapath: load operands on accept, then iterate in MUL or DIV.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         rd_q     <= '0;
         sign_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
      end else if (accept) begin
         op_q     <= op;
         rd_q     <= rd_in;
         cnt_q    <= '0;
         mcand_q  <= {{Width{1'b0}}, op[2] ? opb : opa};
         mplier_q <= op[2] ? opa : opb;
         sign_q   <= sign_new;
         acc_q    <= '0;
         rem_q    <= '0;
         // Fast-path results are loaded pre-signed so FIN passes them through.
         if (op[2] && div_zero) begin
            sign_q <= 1'b0;
            acc_q  <= {{Width{1'b0}}, {Width{1'b1}}};
            rem_q  <= rs1_val;
         end else if (op[2] && div_ovf) begin
            sign_q <= 1'b0;
            acc_q  <= {{Width{1'b0}}, 1'b1, {(Width-1){1'b0}}};
         end
      end else if (state_q == S_MUL) begin
         acc_q    <= mul_acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_shr;
         cnt_q    <= cnt_q + 6'd1;
      end else if (state_q == S_DIV) begin
         rem_q             <= rem_d;
         acc_q[Width-1:0]  <= {acc_q[Width-2:0], div_ge};
         mplier_q          <= mplier_q << 1;
         cnt_q             <= cnt_q + 6'd1;
      end
   end

   // Result registers: done pulses for the cycle after FIN; result holds after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         done_q <= fin_fire;
         if (fin_fire) begin
            result_q <= fin_val;
            rd_out_q <= rd_q;
         end
      end
   end

endmodule
